cache_mem_arbiter: RTL and testbench

CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

---
 rtl/cache_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Cache-to-memory arbiter: shares one memory read channel between the
// icache and dcache, and passes dcache writebacks through an independent
// write channel. Read and write sides run concurrently. A dcache read that
// targets the line of an in-flight or same-cycle write is held off so the
// refill never overtakes its own writeback.
module cache_mem_arbiter #(
  parameter int LINE_BEATS = 4
) (
  input  logic         clk,
  input  logic         reset,
  // icache read
  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,
  // dcache read
  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,
  // dcache write
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_wstrb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  // memory read
  output logic         mem_rd_req,
  output logic [2:0]   mem_rd_type,
  output logic [31:0]  mem_rd_addr,
  input  logic         mem_rd_rdy,
  input  logic         mem_ret_valid,
  input  logic         mem_ret_last,
  input  logic [31:0]  mem_ret_data,
  // memory write
  output logic         mem_wr_req,
  output logic [2:0]   mem_wr_type,
  output logic [31:0]  mem_wr_addr,
  output logic [3:0]   mem_wr_wstrb,
  output logic [127:0] mem_wr_data,
  input  logic         mem_wr_rdy,
  input  logic         mem_wr_done,
  // status
  output logic         proto_err
);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_WAIT = 2'd2
  } wr_state_t;

  localparam logic OWNER_IC = 1'b0;
  localparam logic OWNER_DC = 1'b1;
  localparam logic [7:0] LINE_BEATS_W = 8'(LINE_BEATS);

  rd_state_t      rd_state_r, rd_state_s;
  wr_state_t      wr_state_r, wr_state_s;
  logic           last_grant_r;
  logic           rd_owner_r;
  logic [31:0]    rd_addr_r;
  logic [2:0]     rd_type_r;
  logic [7:0]     beat_cnt_r;
  logic [31:0]    wr_addr_r;
  logic [2:0]     wr_type_r;
  logic [3:0]     wr_wstrb_r;
  logic [127:0]   wr_data_r;
  logic           proto_err_r;

  logic           wr_accept_s;
  logic           line_conflict_s;
  logic           dc_elig_s;
  logic           grant_ic_s;
  logic           grant_dc_s;
  logic           rd_accept_s;
  logic           resp_beat_s;
  logic [7:0]     exp_beats_s;
  logic           beat_err_s;
  logic           stray_err_s;

  assign wr_accept_s = dc_wr_req && (wr_state_r == W_IDLE);
  assign exp_beats_s = (rd_type_r == 3'b100) ? LINE_BEATS_W : 8'd1;
  assign resp_beat_s = (rd_state_r == R_RESP) && mem_ret_valid;
  assign rd_accept_s = grant_ic_s || grant_dc_s;

  // Detect a dcache read hitting the line of a pending or same-cycle write
  always_comb begin
    line_conflict_s = 1'b0;
    if ((wr_state_r != W_IDLE) && (dc_rd_addr[31:4] == wr_addr_r[31:4])) begin
      line_conflict_s = 1'b1;
    end else if (wr_accept_s && (dc_rd_addr[31:4] == dc_wr_addr[31:4])) begin
      line_conflict_s = 1'b1;
    end else begin
      line_conflict_s = 1'b0;
    end
  end

  assign dc_elig_s = dc_rd_req && !line_conflict_s;

  // Read grant: only while idle; a tie goes to whoever lost the last accept
  always_comb begin
    grant_ic_s = 1'b0;
    grant_dc_s = 1'b0;
    if (rd_state_r == R_IDLE) begin
      if (ic_rd_req && dc_elig_s) begin
        if (last_grant_r == OWNER_IC) begin
          grant_dc_s = 1'b1;
        end else begin
          grant_ic_s = 1'b1;
        end
      end else if (ic_rd_req) begin
        grant_ic_s = 1'b1;
      end else if (dc_elig_s) begin
        grant_dc_s = 1'b1;
      end else begin
        grant_ic_s = 1'b0;
        grant_dc_s = 1'b0;
      end
    end else begin
      grant_ic_s = 1'b0;
      grant_dc_s = 1'b0;
    end
  end

  // Read FSM next-state
  always_comb begin
    rd_state_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: begin
        if (rd_accept_s) begin
          rd_state_s = R_REQ;
        end else begin
          rd_state_s = R_IDLE;
        end
      end
      R_REQ: begin
        if (mem_rd_rdy) begin
          rd_state_s = R_RESP;
        end else begin
          rd_state_s = R_REQ;
        end
      end
      R_RESP: begin
        if (mem_ret_valid && mem_ret_last) begin
          rd_state_s = R_IDLE;
        end else begin
          rd_state_s = R_RESP;
        end
      end
      default: rd_state_s = R_IDLE;
    endcase
  end

  // Write FSM next-state
  always_comb begin
    wr_state_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: begin
        if (wr_accept_s) begin
          wr_state_s = W_REQ;
        end else begin
          wr_state_s = W_IDLE;
        end
      end
      W_REQ: begin
        if (mem_wr_rdy) begin
          wr_state_s = W_WAIT;
        end else begin
          wr_state_s = W_REQ;
        end
      end
      W_WAIT: begin
        if (mem_wr_done) begin
          wr_state_s = W_IDLE;
        end else begin
          wr_state_s = W_WAIT;
        end
      end
      default: wr_state_s = W_IDLE;
    endcase
  end

  // Beat-count and stray-event protocol checks
  always_comb begin
    beat_err_s  = 1'b0;
    stray_err_s = 1'b0;
    if (resp_beat_s) begin
      if (mem_ret_last) begin
        beat_err_s = (beat_cnt_r != (exp_beats_s - 8'd1));
      end else begin
        beat_err_s = ((beat_cnt_r + 8'd1) == exp_beats_s);
      end
    end else begin
      beat_err_s = 1'b0;
    end
    if (mem_ret_valid && (rd_state_r != R_RESP)) begin
      stray_err_s = 1'b1;
    end else if (mem_wr_done && (wr_state_r != W_WAIT)) begin
      stray_err_s = 1'b1;
    end else begin
      stray_err_s = 1'b0;
    end
  end

  // Read-side state, latched request fields and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r   <= R_IDLE;
      last_grant_r <= OWNER_IC;
      rd_owner_r   <= OWNER_IC;
      rd_addr_r    <= 32'd0;
      rd_type_r    <= 3'd0;
      beat_cnt_r   <= 8'd0;
    end else begin
      rd_state_r <= rd_state_s;
      if (rd_accept_s) begin
        rd_owner_r   <= grant_dc_s;
        last_grant_r <= grant_dc_s;
        rd_addr_r    <= grant_dc_s ? dc_rd_addr : ic_rd_addr;
        rd_type_r    <= grant_dc_s ? dc_rd_type : ic_rd_type;
        beat_cnt_r   <= 8'd0;
      end else if (resp_beat_s) begin
        beat_cnt_r <= beat_cnt_r + 8'd1;
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end
  end

  // Write-side state and latched write fields
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_r <= W_IDLE;
      wr_addr_r  <= 32'd0;
      wr_type_r  <= 3'd0;
      wr_wstrb_r <= 4'd0;
      wr_data_r  <= 128'd0;
    end else begin
      wr_state_r <= wr_state_s;
      if (wr_accept_s) begin
        wr_addr_r  <= dc_wr_addr;
        wr_type_r  <= dc_wr_type;
        wr_wstrb_r <= dc_wr_wstrb;
        wr_data_r  <= dc_wr_data;
      end else begin
        wr_addr_r  <= wr_addr_r;
      end
    end
  end

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_r <= 1'b0;
    end else if (beat_err_s || stray_err_s) begin
      proto_err_r <= 1'b1;
    end else begin
      proto_err_r <= proto_err_r;
    end
  end

  assign ic_rd_rdy    = grant_ic_s;
  assign dc_rd_rdy    = grant_dc_s;
  assign dc_wr_rdy    = (wr_state_r == W_IDLE);

  assign mem_rd_req   = (rd_state_r == R_REQ);
  assign mem_rd_addr  = rd_addr_r;
  assign mem_rd_type  = rd_type_r;

  assign mem_wr_req   = (wr_state_r == W_REQ);
  assign mem_wr_addr  = wr_addr_r;
  assign mem_wr_type  = wr_type_r;
  assign mem_wr_wstrb = wr_wstrb_r;
  assign mem_wr_data  = wr_data_r;

  // Return beats go straight through to the owner of the current read
  assign ic_ret_valid = resp_beat_s && (rd_owner_r == OWNER_IC);
  assign dc_ret_valid = resp_beat_s && (rd_owner_r == OWNER_DC);
  assign ic_ret_last  = ic_ret_valid && mem_ret_last;
  assign dc_ret_last  = dc_ret_valid && mem_ret_last;
  assign ic_ret_data  = ic_ret_valid ? mem_ret_data : 32'd0;
  assign dc_ret_data  = dc_ret_valid ? mem_ret_data : 32'd0;

  assign proto_err    = proto_err_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a per-cycle vector table for the
// handshake/FSM behaviour plus hand-written sequences for data paths.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_rd_req;
  logic [2:0]   ic_rd_type;
  logic [31:0]  ic_rd_addr;
  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic [31:0]  ic_ret_data;
  logic         dc_rd_req;
  logic [2:0]   dc_rd_type;
  logic [31:0]  dc_rd_addr;
  logic         dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [31:0]  dc_ret_data;
  logic         dc_wr_req;
  logic [2:0]   dc_wr_type;
  logic [31:0]  dc_wr_addr;
  logic [3:0]   dc_wr_wstrb;
  logic [127:0] dc_wr_data;
  logic         dc_wr_rdy;
  logic         mem_rd_req;
  logic [2:0]   mem_rd_type;
  logic [31:0]  mem_rd_addr;
  logic         mem_rd_rdy, mem_ret_valid, mem_ret_last;
  logic [31:0]  mem_ret_data;
  logic         mem_wr_req;
  logic [2:0]   mem_wr_type;
  logic [31:0]  mem_wr_addr;
  logic [3:0]   mem_wr_wstrb;
  logic [127:0] mem_wr_data;
  logic         mem_wr_rdy, mem_wr_done;
  logic         proto_err;

  int n_total = 0;
  int n_pass  = 0;

  cache_mem_arbiter #(.LINE_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last),
    .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr),
    .dc_wr_wstrb(dc_wr_wstrb), .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .mem_rd_req(mem_rd_req), .mem_rd_type(mem_rd_type), .mem_rd_addr(mem_rd_addr),
    .mem_rd_rdy(mem_rd_rdy), .mem_ret_valid(mem_ret_valid), .mem_ret_last(mem_ret_last),
    .mem_ret_data(mem_ret_data),
    .mem_wr_req(mem_wr_req), .mem_wr_type(mem_wr_type), .mem_wr_addr(mem_wr_addr),
    .mem_wr_wstrb(mem_wr_wstrb), .mem_wr_data(mem_wr_data), .mem_wr_rdy(mem_wr_rdy),
    .mem_wr_done(mem_wr_done),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // One clock cycle of stimulus and the outputs expected before its edge.
  // exp = {ic_rd_rdy, dc_rd_rdy, mem_rd_req, mem_wr_req,
  //        ic_ret_valid, dc_ret_valid, dc_wr_rdy, proto_err}
  typedef struct packed {
    logic        rst;
    logic        ic_req;
    logic [2:0]  ic_type;
    logic [31:0] ic_addr;
    logic        dc_req;
    logic [2:0]  dc_type;
    logic [31:0] dc_addr;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic        rd_rdy;
    logic        ret_v;
    logic        ret_l;
    logic        wr_rdy;
    logic        wr_done;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;

  task automatic nv();
    cur = '0;
  endtask

  task automatic add(input logic [7:0] e);
    cur.exp = e;
    vecs.push_back(cur);
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic clear_inputs();
    ic_rd_req = 1'b0; ic_rd_type = 3'b000; ic_rd_addr = 32'd0;
    dc_rd_req = 1'b0; dc_rd_type = 3'b000; dc_rd_addr = 32'd0;
    dc_wr_req = 1'b0; dc_wr_type = 3'b100; dc_wr_addr = 32'd0;
    dc_wr_wstrb = 4'hF; dc_wr_data = 128'd0;
    mem_rd_rdy = 1'b0; mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    mem_ret_data = 32'd0; mem_wr_rdy = 1'b0; mem_wr_done = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    ic_rd_req     = v.ic_req;  ic_rd_type = v.ic_type; ic_rd_addr = v.ic_addr;
    dc_rd_req     = v.dc_req;  dc_rd_type = v.dc_type; dc_rd_addr = v.dc_addr;
    dc_wr_req     = v.wr_req;  dc_wr_addr = v.wr_addr;
    mem_rd_rdy    = v.rd_rdy;
    mem_ret_valid = v.ret_v;   mem_ret_last = v.ret_l;
    mem_ret_data  = 32'h0BAD_F00D;
    mem_wr_rdy    = v.wr_rdy;  mem_wr_done = v.wr_done;
  endtask

  initial begin
    // --- lone icache line read, 4 beats ---
    nv(); add(8'b0000_0010);
    nv(); cur.ic_req = 1'b1; cur.ic_type = 3'b100; cur.ic_addr = 32'h1C00_0040; add(8'b1000_0010);
    nv(); add(8'b0010_0010);
    nv(); add(8'b0010_0010);
    nv(); cur.rd_rdy = 1'b1; add(8'b0010_0010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_1010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_1010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_1010);
    nv(); cur.ret_v = 1'b1; cur.ret_l = 1'b1; cur.ic_req = 1'b1; add(8'b0000_1010);
    nv(); add(8'b0000_0010);
    // --- tie-break fairness ---
    nv(); cur.rst = 1'b1; add(8'b0000_0010);
    for (int k = 0; k < 3; k++) begin
      nv(); cur.ic_req = 1'b1; cur.ic_addr = 32'h10; cur.dc_req = 1'b1; cur.dc_addr = 32'h5000;
      add((k == 1) ? 8'b1000_0010 : 8'b0100_0010);
      nv(); cur.ic_req = (k < 2); cur.dc_req = (k < 2); cur.ic_addr = 32'h10;
      cur.dc_addr = 32'h5000; cur.rd_rdy = 1'b1; add(8'b0010_0010);
      nv(); cur.ic_req = (k < 2); cur.dc_req = (k < 2); cur.ic_addr = 32'h10;
      cur.dc_addr = 32'h5000; cur.ret_v = 1'b1; cur.ret_l = 1'b1;
      add((k == 1) ? 8'b0000_1010 : 8'b0000_0110);
    end
    nv(); add(8'b0000_0010);
    // --- read blocked by pending write to the same line ---
    nv(); cur.wr_req = 1'b1; cur.wr_addr = 32'h1230; add(8'b0000_0010);
    nv(); cur.wr_rdy = 1'b1; add(8'b0001_0000);
    nv(); cur.dc_req = 1'b1; cur.dc_addr = 32'h1234; add(8'b0000_0000);
    nv(); cur.dc_req = 1'b1; cur.dc_addr = 32'h1234; add(8'b0000_0000);
    nv(); cur.dc_req = 1'b1; cur.dc_addr = 32'h1234; cur.wr_done = 1'b1; add(8'b0000_0000);
    nv(); cur.dc_req = 1'b1; cur.dc_addr = 32'h1234; add(8'b0100_0010);
    nv(); cur.rd_rdy = 1'b1; add(8'b0010_0010);
    nv(); cur.ret_v = 1'b1; cur.ret_l = 1'b1; add(8'b0000_0110);
    // --- other line proceeds while write pending ---
    nv(); cur.wr_req = 1'b1; cur.wr_addr = 32'h1230; add(8'b0000_0010);
    nv(); cur.dc_req = 1'b1; cur.dc_addr = 32'h2000; add(8'b0101_0000);
    nv(); cur.rd_rdy = 1'b1; cur.wr_rdy = 1'b1; add(8'b0011_0000);
    nv(); cur.ret_v = 1'b1; cur.ret_l = 1'b1; cur.wr_done = 1'b1; add(8'b0000_0100);
    nv(); add(8'b0000_0010);
    // --- same-cycle read and write accepts ---
    nv(); cur.wr_req = 1'b1; cur.wr_addr = 32'h100; cur.dc_req = 1'b1; cur.dc_addr = 32'h200; add(8'b0100_0010);
    nv(); add(8'b0011_0000);
    nv(); cur.rd_rdy = 1'b1; cur.wr_rdy = 1'b1; add(8'b0011_0000);
    nv(); cur.ret_v = 1'b1; cur.ret_l = 1'b1; cur.wr_done = 1'b1; add(8'b0000_0100);
    nv(); add(8'b0000_0010);
    nv(); cur.wr_req = 1'b1; cur.wr_addr = 32'h300; cur.dc_req = 1'b1; cur.dc_addr = 32'h304; add(8'b0000_0010);
    nv(); cur.wr_rdy = 1'b1; add(8'b0001_0000);
    nv(); cur.wr_done = 1'b1; add(8'b0000_0000);
    nv(); add(8'b0000_0010);
    // --- protocol errors ---
    nv(); cur.ic_req = 1'b1; cur.ic_type = 3'b100; cur.ic_addr = 32'h40; add(8'b1000_0010);
    nv(); cur.rd_rdy = 1'b1; add(8'b0010_0010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_1010);
    nv(); cur.ret_v = 1'b1; cur.ret_l = 1'b1; add(8'b0000_1010);
    nv(); add(8'b0000_0011);
    nv(); cur.ret_v = 1'b1; add(8'b0000_0011);
    nv(); cur.wr_done = 1'b1; add(8'b0000_0011);
    nv(); cur.rst = 1'b1; add(8'b0000_0011);
    nv(); add(8'b0000_0010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_0010);
    nv(); add(8'b0000_0011);
    nv(); cur.rst = 1'b1; add(8'b0000_0011);
    nv(); cur.dc_req = 1'b1; cur.dc_addr = 32'h700; add(8'b0100_0010);
    nv(); cur.rd_rdy = 1'b1; add(8'b0010_0010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_0110);
    nv(); cur.ret_v = 1'b1; cur.ret_l = 1'b1; add(8'b0000_0111);
    nv(); add(8'b0000_0011);
    nv(); cur.rst = 1'b1; add(8'b0000_0011);
    nv(); cur.wr_done = 1'b1; add(8'b0000_0010);
    nv(); add(8'b0000_0011);
    // --- reset during beat 2 of a line read ---
    nv(); cur.rst = 1'b1; add(8'b0000_0011);
    nv(); cur.ic_req = 1'b1; cur.ic_type = 3'b100; cur.ic_addr = 32'h80; add(8'b1000_0010);
    nv(); cur.rd_rdy = 1'b1; add(8'b0010_0010);
    nv(); cur.ret_v = 1'b1; add(8'b0000_1010);
    nv(); cur.ret_v = 1'b1; cur.rst = 1'b1; add(8'b0000_1010);
    nv(); add(8'b0000_0010);

    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("vec%0d", i),
          {ic_rd_rdy, dc_rd_rdy, mem_rd_req, mem_wr_req,
           ic_ret_valid, dc_ret_valid, dc_wr_rdy, proto_err},
          vecs[i].exp);
    end

    // --- data path: line read forwarding and address hold ---
    @(negedge clk);
    clear_inputs(); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rd_addr", mem_rd_addr, 32'd0);
    chk("rst_wr_data", mem_wr_data, 128'd0);
    ic_rd_req = 1'b1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1C00_0040;
    @(negedge clk);
    ic_rd_req = 1'b0; ic_rd_addr = 32'h0;
    #1;
    chk("rd_addr", mem_rd_addr, 32'h1C00_0040);
    chk("rd_type", mem_rd_type, 3'b100);
    mem_rd_rdy = 1'b1;
    @(negedge clk);
    mem_rd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_ret_valid = 1'b1;
      mem_ret_last  = (b == 3);
      mem_ret_data  = 32'hD000_0000 + 32'(b);
      #1;
      chk($sformatf("ic_data%0d", b), ic_ret_data, 32'hD000_0000 + 32'(b));
      chk($sformatf("ic_last%0d", b), ic_ret_last, (b == 3));
      chk($sformatf("dc_quiet%0d", b), {dc_ret_valid, dc_ret_last}, 2'b00);
      @(negedge clk);
    end
    mem_ret_valid = 1'b0; mem_ret_last = 1'b0;
    #1;
    chk("rd_addr_hold", mem_rd_addr, 32'h1C00_0040);
    chk("no_err_line", proto_err, 1'b0);

    // --- data path: word write fields latched and held ---
    dc_wr_req = 1'b1; dc_wr_type = 3'b010; dc_wr_addr = 32'h0000_1238;
    dc_wr_wstrb = 4'b0110; dc_wr_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    @(negedge clk);
    dc_wr_req = 1'b0; dc_wr_addr = 32'd0; dc_wr_wstrb = 4'd0; dc_wr_data = 128'd0;
    #1;
    chk("wr_req", mem_wr_req, 1'b1);
    chk("wr_addr", mem_wr_addr, 32'h0000_1238);
    chk("wr_type", mem_wr_type, 3'b010);
    chk("wr_wstrb", mem_wr_wstrb, 4'b0110);
    chk("wr_data", mem_wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    mem_wr_rdy = 1'b1;
    @(negedge clk);
    mem_wr_rdy = 1'b0; mem_wr_done = 1'b1;
    #1;
    chk("wr_wait", {mem_wr_req, dc_wr_rdy}, 2'b00);
    @(negedge clk);
    mem_wr_done = 1'b0;
    #1;
    chk("wr_idle", dc_wr_rdy, 1'b1);
    chk("wr_data_hold", mem_wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    chk("no_err_wr", proto_err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
